// File: rtl/splitter_ctrl_pkg.sv
// Shared types and constants for the splitter pulse arbiter: FSM state encoding
// and the bit positions inside the sticky error vector.
package splitter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FIRE     = 2'd1,
    WAIT_OUT = 2'd2,
    GAP      = 2'd3
  } state_e;

  localparam int ERR_W     = 3;
  localparam int ERR_MISS1 = 0;
  localparam int ERR_MISS2 = 1;
  localparam int ERR_SPUR  = 2;

endpackage

// File: rtl/splitter_pulse_arbiter_rr_arbiter.sv
// Round-robin requester pick. ptr remembers the last granted index and the
// search starts one past it, so a freshly reset arbiter favours index 0.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic                    grant,
  output logic [$clog2(NREQ)-1:0] win_idx,
  output logic                    win_valid
);

  localparam int IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    int idx;
    win_idx   = '0;
    win_valid = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!win_valid && req[idx]) begin
        win_valid = 1'b1;
        win_idx   = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = grant ? win_idx : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= IDX_W'(NREQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/splitter_pulse_arbiter.sv
// Shares one splitter input among NREQ requesters: fires one pulse per grant,
// then checks that each splitter output answers exactly once before a timeout.
module splitter_pulse_arbiter
  import splitter_ctrl_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MIN_GAP = 3,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic             pulse_out,
  input  logic             out1,
  input  logic             out2,
  input  logic             err_clr,
  output logic             busy,
  output logic [ERR_W-1:0] err_flags,
  output logic [CNT_W-1:0] pulse_cnt
);

  localparam int     IDX_W    = $clog2(NREQ);
  localparam int     TMAX     = (TIMEOUT > MIN_GAP) ? TIMEOUT : MIN_GAP;
  localparam int     TMR_W    = $clog2(TMAX + 1);
  localparam int     MASK_W   = $clog2(TIMEOUT + 1);
  localparam int     GAP_LAST = (MIN_GAP > 0) ? MIN_GAP - 1 : 0;
  localparam state_e AFTER_WAIT = (MIN_GAP > 0) ? GAP : IDLE;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic             seen1_q, seen1_d;
  logic             seen2_q, seen2_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             pulse_q;
  logic             busy_q;
  logic [ERR_W-1:0] err_q, err_d, err_set;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;
  logic             spur_armed;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .grant     (grant),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  // Outputs seen outside the response window are stragglers unless they
  // could still belong to a pulse that was cut short by reset.
  assign spur_armed = (mask_q == '0);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    seen1_d = seen1_q;
    seen2_d = seen2_q;
    gnt_d   = '0;
    grant   = 1'b0;
    err_set = '0;
    case (state_q)
      IDLE: begin
        if ((out1 || out2) && spur_armed) err_set[ERR_SPUR] = 1'b1;
        if (win_valid) begin
          grant          = 1'b1;
          gnt_d[win_idx] = 1'b1;
          state_d        = FIRE;
        end
      end
      FIRE: begin
        seen1_d = out1;
        seen2_d = out2;
        tmr_d   = '0;
        state_d = WAIT_OUT;
      end
      WAIT_OUT: begin
        seen1_d = seen1_q || out1;
        seen2_d = seen2_q || out2;
        if ((out1 && seen1_q) || (out2 && seen2_q)) err_set[ERR_SPUR] = 1'b1;
        if (seen1_d && seen2_d) begin
          state_d = AFTER_WAIT;
          tmr_d   = '0;
        end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          err_set[ERR_MISS1] = !seen1_d;
          err_set[ERR_MISS2] = !seen2_d;
          state_d            = AFTER_WAIT;
          tmr_d              = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      GAP: begin
        if ((out1 || out2) && spur_armed) err_set[ERR_SPUR] = 1'b1;
        if (tmr_q == TMR_W'(GAP_LAST)) state_d = IDLE;
        else                           tmr_d   = tmr_q + TMR_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // A clear and a fresh error in the same cycle leave the fresh bit set.
  always_comb begin
    err_d  = (err_clr ? '0 : err_q) | err_set;
    cnt_d  = (state_q == FIRE) ? cnt_q + CNT_W'(1) : cnt_q;
    mask_d = (mask_q != '0) ? mask_q - MASK_W'(1) : mask_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      mask_q  <= MASK_W'(TIMEOUT);
      seen1_q <= 1'b0;
      seen2_q <= 1'b0;
      gnt_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      mask_q  <= mask_d;
      seen1_q <= seen1_d;
      seen2_q <= seen2_d;
      gnt_q   <= gnt_d;
      pulse_q <= (state_d == FIRE);
      busy_q  <= (state_d != IDLE);
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign err_flags = err_q;
  assign pulse_cnt = cnt_q;

endmodule

// File: doc/splitter_pulse_arbiter.md
# splitter_pulse_arbiter

Shares one basic splitter input between NREQ requesters and checks the splitter's response. Each granted request produces one single-cycle pulse on the splitter input. The block then requires exactly one pulse on each splitter output within a timeout, and enforces a recovery gap before the next pulse. It sits between the stimulus/sequencer logic and the splitter DUT in our pulse-level benches and models.

## Interface
Parameters:
- NREQ, 4, number of requesters (≥2)
- MIN_GAP, 3, idle cycles enforced after each response window (0 allowed: GAP skipped)
- TIMEOUT, 8, max WAIT_OUT cycles for both outputs to arrive (≥1)
- CNT_W, 16, width of pulse counter

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req  in  NREQ  request per requester; held until gnt
- gnt  out  NREQ  one-hot, high for exactly the FIRE cycle
- pulse_out  out  1  splitter input pulse, high one cycle (FIRE)
- out1  in  1  splitter output 1 pulse
- out2  in  1  splitter output 2 pulse
- err_clr  in  1  clears sticky err_flags
- busy  out  1  high whenever state ≠ IDLE
- err_flags  out  3  sticky: [0] out1 missing, [1] out2 missing, [2] spurious output pulse
- pulse_cnt  out  CNT_W  pulses issued, wraps modulo 2^CNT_W

## Operation
- All outputs are registered. On reset: state IDLE; gnt=0, pulse_out=0, busy=0, err_flags=0, pulse_cnt=0. The round-robin pointer resets so that index 0 has top priority.
- FSM states: IDLE → FIRE → WAIT_OUT → GAP → IDLE.
- IDLE: if req≠0, pick the winner round-robin, searching from ptr+1 mod NREQ. ptr holds the last granted index; reset value is NREQ-1. Next state is FIRE.
- FIRE (1 cycle): pulse_out=1 and gnt[winner]=1. Update ptr to winner; increment pulse_cnt. Clear seen1/seen2, then sample out1/out2 in this cycle. Next state is WAIT_OUT.
- WAIT_OUT:
  - Set seen1/seen2 on out1/out2. A second pulse on an already-seen output sets err_flags[2].
  - Exit to GAP at the end of a cycle in which seen1&seen2 holds, counting pulses that arrive in that cycle.
  - If both are not seen by the end of the TIMEOUT-th WAIT_OUT cycle, set err_flags[0] if !seen1 and err_flags[1] if !seen2, then go to GAP.
- GAP: hold MIN_GAP cycles with pulse_out=0, then go to IDLE. With MIN_GAP=0, WAIT_OUT goes directly to IDLE.
- A pulse on out1 or out2 in IDLE or GAP sets err_flags[2]. This check is masked for the first TIMEOUT cycles after reset release, so stragglers from an aborted pulse are not flagged.
- err_clr clears err_flags; a new error in the same cycle wins (its bit remains set).
- req deasserted before grant: that request is dropped silently. req still high the cycle after gnt: treated as a new request.

## Timing
- Latency: req sampled high at edge k (state IDLE) gives pulse_out/gnt high in cycle k+1.
- Minimum pulse period is MIN_GAP+3 cycles: IDLE 1 + FIRE 1 + WAIT_OUT ≥1 + GAP MIN_GAP.
- An output arriving in the TIMEOUT-th WAIT_OUT cycle is on time; one cycle later it is spurious (IDLE/GAP).
- Reset mid-operation: at the next edge with rst_n=0, state and all outputs take their reset values. The in-flight pulse is forgotten with no error.
- pulse_cnt wraps from 2^CNT_W−1 to 0 with no flag.

## Structure
- Package splitter_ctrl_pkg holds:
  - the state enum (IDLE, FIRE, WAIT_OUT, GAP);
  - err_flags bit-index constants (ERR_MISS1=0, ERR_MISS2=1, ERR_SPUR=2).
- Sub-module rr_arbiter (parameter NREQ) holds:
  - combinational round-robin pick (winner index and valid) from req and ptr;
  - the ptr register, updated on a grant strobe.
- The top level holds the FSM, timers, seen flags, the error logic, and the counter.

## Test plan
- Single request: req=4'b0001 for one edge → gnt=0001 and pulse_out high for 1 cycle; out1/out2 returned 2 cycles later → busy low after WAIT_OUT + 3 GAP cycles; pulse_cnt=1; err_flags=000.
- Fairness: req=4'b1111 held, outputs returned promptly → grant order 0,1,2,3,0; pulses exactly 6 cycles apart; err_flags=000.
- Missing output: after FIRE return only out1 → at end of WAIT_OUT cycle 8 err_flags=010; FSM continues through GAP to IDLE.
- Spurious: out2 pulsed in GAP → err_flags=100. Then err_clr together with a duplicate out1 in WAIT_OUT → err_flags remains 100.
- Reset mid-flight: rst_n=0 during WAIT_OUT, released, then out1/out2 pulsed 2 cycles later → all outputs 0 after reset; err_flags stays 000 because the spurious check is masked.
- Counter wrap: CNT_W=2, five pulses → pulse_cnt sequence 1,2,3,0,1.
